// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks x0..x(NREGS-1) through a borrowed reg_file read port
// and streams each register value out over a valid/ready interface.
module reg_dump_reader #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rf_sel,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [XLEN-1:0]   data_d;
  logic              last_d;
  logic              rf_sel_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_data_q;
  logic [ADDR_W-1:0] out_idx_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;

  // Next index, captured value (x0 always reads as zero) and last-beat flag
  always_comb begin
    idx_d  = idx_q + ADDR_W'(1);
    data_d = (idx_q == '0) ? '0 : rf_rdata;
    last_d = (idx_q == LAST_IDX);
  end

  // Dump FSM with all outputs registered; abort overrides handshake and start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rf_sel_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q     <= IDLE;
        idx_q       <= '0;
        rf_sel_q    <= 1'b0;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q  <= READ;
              idx_q    <= '0;
              rf_sel_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          READ: begin
            out_data_q  <= data_d;
            out_idx_q   <= idx_q;
            out_last_q  <= last_d;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
          SEND: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (out_last_q) begin
                state_q  <= DONE;
                rf_sel_q <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                idx_q   <= idx_d;
                state_q <= READ;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rf_sel    = rf_sel_q;
  assign rf_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader with a behavioural reg_file model.
module tb_reg_dump_reader;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        rf_sel;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  // reg_file model: x0 deliberately writable so the DUT's zero forcing is visible
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];

  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;
  int    cyc      = 0;
  beat_t sb [$];
  beat_t mon_e;

  reg_dump_reader #(
    .XLEN  (32),
    .NREGS (32),
    .ADDR_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rf_sel   (rf_sel),
    .rf_addr  (rf_addr),
    .rf_rdata (rf_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (we3) rf[a3] <= wd3;

  assign rf_rdata = rf[rf_addr];

  // Monitor: compare every presented beat with the scoreboard head, pop on acceptance
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got idx %0d data %h, required no beat", out_idx, out_data);
      end else begin
        mon_e = sb[0];
        checks++;
        if (out_data !== mon_e.data || out_idx !== mon_e.idx || out_last !== mon_e.last) begin
          errors++;
          $display("FAIL beat: got idx %0d data %h last %0b, required idx %0d data %h last %0b",
                   out_idx, out_data, out_last, mon_e.idx, mon_e.data, mon_e.last);
        end
        if (out_ready && !abort) void'(sb.pop_front());
      end
    end
    if (rst_n && done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we3 = 1'b1;
    a3  = 5'(a);
    wd3 = d;
    tick();
    we3 = 1'b0;
    exp_rf[a] = d;
  endtask

  task automatic push_range(input int lo, input int hi);
    beat_t e;
    for (int i = lo; i <= hi; i++) begin
      e.data = (i == 0) ? 32'h0 : exp_rf[i];
      e.idx  = 5'(i);
      e.last = (i == 31);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid_idx(input int i);
    int n = 0;
    while (!(out_valid && out_idx == 5'(i)) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_idx: got timeout, required beat idx %0d", i);
    end
  endtask

  task automatic wait_read(input int i);
    int n = 0;
    while (!(rf_sel && rf_addr == 5'(i) && !out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_read: got timeout, required read of idx %0d", i);
    end
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    at = cyc;
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout, required done pulse");
    end
  endtask

  initial begin
    int s;
    int at;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    we3       = 1'b0;
    a3        = '0;
    wd3       = '0;

    // Load the register file while the DUT is held in reset
    wr(0, 32'hBAD0BAD0);
    wr(1, 32'h0000FFFF);
    wr(2, 32'hFFFF0000);
    wr(3, 32'h12345678);
    wr(4, 32'h04040404);
    wr(5, 32'hA5A5A5A5);
    for (int i = 6; i < 32; i++) wr(i, 32'h01010101 * 32'(i));

    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_busy",  {31'b0, busy},      32'h0);
    chk("reset_sel",   {31'b0, rf_sel},    32'h0);
    chk("reset_addr",  {27'b0, rf_addr},   32'h0);
    chk("reset_data",  out_data,           32'h0);
    chk("reset_done",  {31'b0, done},      32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // Dump 1: backpressure on idx3, coherence write on idx5, start at idx12
    push_range(0, 31);
    s = cyc;
    pulse_start();
    wait_valid_idx(3);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_idx",   {27'b0, out_idx},   32'd3);
      chk("bp_data",  out_data,           32'h12345678);
    end
    out_ready = 1'b1;
    wait_read(5);
    wr(5, 32'hDEADBEEF);
    wait_valid_idx(12);
    pulse_start();
    wait_done(at);
    chk("dump1_done_cycle", 32'(at), 32'(s + 70));
    chk("dump1_busy_with_done", {31'b0, busy}, 32'h1);
    tick();
    chk("dump1_done_width", {31'b0, done}, 32'h0);
    chk("dump1_busy_after", {31'b0, busy}, 32'h0);
    repeat (4) tick();
    chk("dump1_done_count", 32'(done_cnt), 32'd1);
    chk("dump1_sb_empty", 32'(sb.size()), 32'd0);

    // Dump 2: abort while idx10 is being offered with ready high
    push_range(0, 10);
    pulse_start();
    wait_valid_idx(10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {31'b0, out_valid}, 32'h0);
    chk("abort_busy",  {31'b0, busy},      32'h0);
    chk("abort_unaccepted", 32'(sb.size()), 32'd1);
    sb.delete();
    repeat (5) tick();
    chk("abort_no_done", 32'(done_cnt), 32'd1);

    // Dump 3: clean dump, shows the coherence write and exact timing
    push_range(0, 31);
    s = cyc;
    pulse_start();
    wait_done(at);
    chk("dump3_done_cycle", 32'(at), 32'(s + 65));
    tick();
    chk("dump3_busy_after", {31'b0, busy}, 32'h0);
    chk("dump3_done_count", 32'(done_cnt), 32'd2);
    chk("dump3_sb_empty", 32'(sb.size()), 32'd0);

    // Dump 4: asynchronous reset while idx7 is held in SEND
    push_range(0, 6);
    pulse_start();
    wait_valid_idx(7);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_busy",  {31'b0, busy},      32'h0);
    chk("arst_sel",   {31'b0, rf_sel},    32'h0);
    chk("arst_idx",   {27'b0, out_idx},   32'h0);
    chk("arst_data",  out_data,           32'h0);
    chk("arst_addr",  {27'b0, rf_addr},   32'h0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("post_rst_busy",  {31'b0, busy},      32'h0);
    chk("post_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("post_rst_done",  32'(done_cnt),      32'd2);
    chk("post_rst_sb",    32'(sb.size()),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Read-side companion to the single-cycle reg_file. On a start pulse it borrows one combinational read port (address/data pair) and walks x0..x(NREGS-1). It streams each register value out over a valid/ready interface to the debug/trace path (testbench monitor, UART dumper). The core keeps writing through the write port while a dump is in progress.

Parameters:
XLEN, 32, data width of one register
NREGS, 32, number of registers dumped (power of two, at most 2^ADDR_W)
ADDR_W, 5, register address width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a dump; ignored unless IDLE
abort  in  1  synchronous cancel; returns to IDLE without done
rf_sel  out  1  high while block owns the reg_file read port (mux select for a1)
rf_addr  out  ADDR_W  read address driven to reg_file a1
rf_rdata  in  XLEN  combinational read data from reg_file rd1
out_valid  out  1  out_data/out_idx/out_last valid
out_ready  in  1  sink accepts beat when high with out_valid
out_data  out  XLEN  captured register value
out_idx  out  ADDR_W  register index of current beat
out_last  out  1  high on beat for index NREGS-1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; rf_sel=0, rf_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0. Takes effect immediately mid-dump; no beat or done after release until a new start.
- States: IDLE, READ, SEND, DONE.
- IDLE: start=1 at edge -> READ, idx=0. Outputs rf_sel=0, busy=0.
- READ: rf_sel=1, rf_addr=idx. At the edge: out_data<=rf_rdata (forced 0 when idx==0), out_idx<=idx, out_last<=(idx==NREGS-1), out_valid<=1 -> SEND.
- SEND: out_valid=1; out_data/out_idx/out_last held stable while out_ready=0. rf_sel=1, rf_addr=idx. Handshake (out_valid&out_ready) at edge: out_valid<=0. If last -> DONE, else idx<=idx+1 -> READ.
- DONE: done=1 for exactly one cycle, rf_sel=0 -> IDLE. busy=1 in READ/SEND/DONE.
- Throughput: one beat per 2 cycles with out_ready tied high. Full dump = 2*NREGS cycles from start edge to last handshake; done high in the following cycle.
- Write coherence: value captured is the reg_file content before the capture edge. A write to the same address at that same edge is not reflected. Writes to already-dumped or not-yet-read registers are not tracked.
- abort=1 at an edge in READ/SEND/DONE -> IDLE, out_valid<=0, no done. abort has priority over handshake and start.
- start while busy: ignored. start and abort together in IDLE: stay IDLE.
- idx counter is ADDR_W bits and never wraps past NREGS-1.

Test Plan:
- Basic dump: write x1=0x0000FFFF, x2=0xFFFF0000 via we3/a3/wd3, pulse start, out_ready=1 -> 32 beats idx 0..31. idx0 data 0, idx1 0x0000FFFF, idx2 0xFFFF0000. out_last only on idx31. done pulse one cycle after the 32nd handshake (cycle 65 after start edge). busy falls with done.
- Backpressure: out_ready=0 for 5 cycles on idx3 (x3=0x12345678) -> out_valid stays 1, out_data=0x12345678, out_idx=3 stable. Next beat idx4 only after ready rises.
- Coherence: during READ of idx5, write x5=0xDEADBEEF at the capture edge (old value 0xA5A5A5A5) -> beat idx5 carries 0xA5A5A5A5. Second dump shows 0xDEADBEEF.
- Abort: abort during SEND of idx10 -> out_valid 0 next cycle, busy 0, no done. New start dumps from idx0.
- Async reset mid-dump: rst_n low between edges while in SEND idx7 -> all outputs 0 immediately. After release, no activity without start.
- Start while busy: pulse start at idx12 -> ignored. Beat sequence continues 13, 14, ... and exactly one done.
